// File: rtl/scratchpad_bank_arbiter.sv
// Round-robin arbiter with atomic lock support that shares one scratchpad bank among NREQ requesters.
// Optional per-requester conflict counters are enabled by defining SCRATCHPAD_ARB_PERF_CNT_EN.
module scratchpad_bank_arbiter #(
    parameter int NREQ = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ-1:0]       req_we,
    input  logic [NREQ-1:0]       req_lock,
    input  logic [NREQ-1:0][7:0]  req_addr,
    input  logic [NREQ-1:0][31:0] req_wdata,
    output logic [NREQ-1:0]       req_ready,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  bank_ren,
    output logic                  bank_wen,
    output logic [7:0]            bank_addr,
    output logic [31:0]           bank_wdata,
    input  logic [31:0]           bank_rdata,
    input  logic                  bank_rvalid
`ifdef SCRATCHPAD_ARB_PERF_CNT_EN
    ,
    output logic [NREQ-1:0][15:0] conflict_cnt
`endif
);

    localparam int DATA_W = 32;
    localparam int ADDR_W = 8;
    localparam int IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {ARB, LOCKED} state_t;

    state_t             state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   lock_owner;
    logic [IDX_W-1:0]   gidx;
    logic [IDX_W-1:0]   cand;
    logic               xfer;
    logic               inflight_vld_p1;
    logic [IDX_W-1:0]   inflight_idx_p1;

    // Stage 0: grant selection. Reset masks every grant so no strobe leaks out while rst is high.
    always_comb begin
        req_ready = '0;
        gidx      = '0;
        cand      = '0;
        xfer      = 1'b0;
        if (!rst) begin
            if (state == LOCKED) begin
                if (req_valid[lock_owner]) begin
                    req_ready[lock_owner] = 1'b1;
                    gidx                  = lock_owner;
                    xfer                  = 1'b1;
                end
            end else begin
                for (int k = 1; k <= NREQ; k++) begin
                    cand = IDX_W'((int'(rr_ptr) + k) % NREQ);
                    if (!xfer && req_valid[cand]) begin
                        req_ready[cand] = 1'b1;
                        gidx            = cand;
                        xfer            = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        bank_ren   = 1'b0;
        bank_wen   = 1'b0;
        bank_addr  = '0;
        bank_wdata = '0;
        if (xfer) begin
            bank_ren   = ~req_we[gidx];
            bank_wen   = req_we[gidx];
            bank_addr  = req_addr[gidx][ADDR_W-1:0];
            bank_wdata = req_wdata[gidx][DATA_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ARB;
            rr_ptr          <= IDX_W'(NREQ - 1);
            lock_owner      <= '0;
            inflight_vld_p1 <= 1'b0;
        end else begin
            inflight_vld_p1 <= xfer;
            if (xfer) begin
                rr_ptr <= gidx;
                if (state == ARB && req_lock[gidx]) begin
                    state      <= LOCKED;
                    lock_owner <= gidx;
                end else if (state == LOCKED && !req_lock[gidx]) begin
                    state <= ARB;
                end
            end
        end
    end

    // Stage 1: in-flight requester index, qualified by inflight_vld_p1.
    always_ff @(posedge clk) begin
        if (xfer) begin
            inflight_idx_p1 <= gidx;
        end
    end

    // A stray bank_rvalid with nothing in flight, or one arriving during reset, is discarded.
    always_comb begin
        rsp_valid = '0;
        rsp_rdata = '0;
        if (!rst && inflight_vld_p1 && bank_rvalid) begin
            rsp_valid[inflight_idx_p1] = 1'b1;
            rsp_rdata                  = bank_rdata;
        end
    end

`ifdef SCRATCHPAD_ARB_PERF_CNT_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_cnt <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && !req_ready[i]) begin
                    conflict_cnt[i] <= sat_inc16(conflict_cnt[i]);
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_scratchpad_bank_arbiter.sv
// Directed bench for scratchpad_bank_arbiter (NREQ=2) with a one-cycle write-through bank model.
// Counter checks are compiled in when SCRATCHPAD_ARB_PERF_CNT_EN is defined.
module tb_scratchpad_bank_arbiter;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       req_valid;
    logic [1:0]       req_we;
    logic [1:0]       req_lock;
    logic [1:0][7:0]  req_addr;
    logic [1:0][31:0] req_wdata;
    logic [1:0]       req_ready;
    logic [1:0]       rsp_valid;
    logic [31:0]      rsp_rdata;
    logic             bank_ren;
    logic             bank_wen;
    logic [7:0]       bank_addr;
    logic [31:0]      bank_wdata;
    logic [31:0]      bank_rdata = '0;
    logic             bank_rvalid;
    logic             bank_rv_q = 1'b0;
    logic             inj_rvalid;
`ifdef SCRATCHPAD_ARB_PERF_CNT_EN
    logic [1:0][15:0] conflict_cnt;
`endif

    int total = 0;
    int fails = 0;

    scratchpad_bank_arbiter #(.NREQ(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_we      (req_we),
        .req_lock    (req_lock),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .bank_ren    (bank_ren),
        .bank_wen    (bank_wen),
        .bank_addr   (bank_addr),
        .bank_wdata  (bank_wdata),
        .bank_rdata  (bank_rdata),
        .bank_rvalid (bank_rvalid)
`ifdef SCRATCHPAD_ARB_PERF_CNT_EN
        ,
        .conflict_cnt(conflict_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Bank: one-cycle latency, write returns the written word.
    logic [31:0]  mem [256];
    logic [255:0] written = '0;

    function automatic logic [31:0] init_word(input logic [7:0] a);
        case (a)
            8'h10:   return 32'hDEADBEEF;
            8'h20:   return 32'hCAFEF00D;
            8'h05:   return 32'h05050505;
            default: return {24'h0, a};
        endcase
    endfunction

    always @(posedge clk) begin
        bank_rv_q <= bank_ren | bank_wen;
        if (bank_wen) begin
            mem[bank_addr]     <= bank_wdata;
            written[bank_addr] <= 1'b1;
            bank_rdata         <= bank_wdata;
        end else begin
            bank_rdata <= written[bank_addr] ? mem[bank_addr] : init_word(bank_addr);
        end
    end

    assign bank_rvalid = bank_rv_q | inj_rvalid;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] we, input logic [1:0] lk,
                         input logic [7:0] a0, input logic [7:0] a1,
                         input logic [31:0] d0, input logic [31:0] d1);
        req_valid    = v;
        req_we       = we;
        req_lock     = lk;
        req_addr[0]  = a0;
        req_addr[1]  = a1;
        req_wdata[0] = d0;
        req_wdata[1] = d1;
        #1;
    endtask

    task automatic idle();
        drive(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0);
    endtask

    initial begin
        rst        = 1'b1;
        inj_rvalid = 1'b0;
        req_valid  = '0;
        req_we     = '0;
        req_lock   = '0;
        req_addr   = '0;
        req_wdata  = '0;

        // Reset holds every output low even with requests present
        next_cycle();
        next_cycle();
        drive(2'b11, 2'b01, 2'b00, 8'h33, 8'h44, 32'h11111111, 32'h0);
        chk("rst_ready", 64'(req_ready), 64'(2'b00));
        chk("rst_wen", 64'(bank_wen), 64'(1'b0));
        chk("rst_ren", 64'(bank_ren), 64'(1'b0));
        chk("rst_addr", 64'(bank_addr), 64'(8'h00));
        chk("rst_wdata", 64'(bank_wdata), 64'(32'h0));
        chk("rst_rsp", 64'(rsp_valid), 64'(2'b00));
        chk("rst_rdata", 64'(rsp_rdata), 64'(32'h0));

        // Single read of 0x10 by requester 0
        next_cycle();
        rst = 1'b0;
        drive(2'b01, 2'b00, 2'b00, 8'h10, 8'h00, 32'h0, 32'h0);
        chk("rd_ready", 64'(req_ready), 64'(2'b01));
        chk("rd_ren", 64'(bank_ren), 64'(1'b1));
        chk("rd_wen", 64'(bank_wen), 64'(1'b0));
        chk("rd_addr", 64'(bank_addr), 64'(8'h10));
        next_cycle();
        idle();
        chk("rd_rsp", 64'(rsp_valid), 64'(2'b01));
        chk("rd_rdata", 64'(rsp_rdata), 64'(32'hDEADBEEF));
        chk("idle_ren", 64'(bank_ren), 64'(1'b0));
        chk("idle_addr", 64'(bank_addr), 64'(8'h00));
        next_cycle();
        idle();
        chk("rd_rsp_gone", 64'(rsp_valid), 64'(2'b00));

        // Contention after reset: rr_ptr=1 so requester 0 leads, then strict alternation
        next_cycle();
        rst = 1'b1;
        idle();
        next_cycle();
        rst = 1'b0;
        drive(2'b11, 2'b00, 2'b00, 8'h10, 8'h20, 32'h0, 32'h0);
        chk("ct1_ready", 64'(req_ready), 64'(2'b01));
        chk("ct1_rsp", 64'(rsp_valid), 64'(2'b00));
        next_cycle();
        drive(2'b11, 2'b00, 2'b00, 8'h10, 8'h20, 32'h0, 32'h0);
        chk("ct2_ready", 64'(req_ready), 64'(2'b10));
        chk("ct2_addr", 64'(bank_addr), 64'(8'h20));
        chk("ct2_rsp", 64'(rsp_valid), 64'(2'b01));
        chk("ct2_rdata", 64'(rsp_rdata), 64'(32'hDEADBEEF));
        next_cycle();
        drive(2'b11, 2'b00, 2'b00, 8'h10, 8'h20, 32'h0, 32'h0);
        chk("ct3_ready", 64'(req_ready), 64'(2'b01));
        chk("ct3_rsp", 64'(rsp_valid), 64'(2'b10));
        chk("ct3_rdata", 64'(rsp_rdata), 64'(32'hCAFEF00D));
        next_cycle();
        drive(2'b11, 2'b00, 2'b00, 8'h10, 8'h20, 32'h0, 32'h0);
        chk("ct4_ready", 64'(req_ready), 64'(2'b10));
        chk("ct4_rsp", 64'(rsp_valid), 64'(2'b01));
        next_cycle();
        idle();
        chk("ct5_ready", 64'(req_ready), 64'(2'b00));
        chk("ct5_rsp", 64'(rsp_valid), 64'(2'b10));
        chk("ct5_rdata", 64'(rsp_rdata), 64'(32'hCAFEF00D));

        // Lock: requester 0 takes a slot so requester 1 gets priority for its atomic pair
        next_cycle();
        drive(2'b01, 2'b00, 2'b00, 8'h10, 8'h00, 32'h0, 32'h0);
        chk("lk0_ready", 64'(req_ready), 64'(2'b01));
        next_cycle();
        drive(2'b11, 2'b00, 2'b10, 8'h10, 8'h20, 32'h0, 32'h0);
        chk("lk1_ready", 64'(req_ready), 64'(2'b10));
        chk("lk1_ren", 64'(bank_ren), 64'(1'b1));
        next_cycle();
        drive(2'b01, 2'b00, 2'b00, 8'h10, 8'h20, 32'h0, 32'h0);
        chk("lk2_ready_held", 64'(req_ready), 64'(2'b00));
        chk("lk2_ren", 64'(bank_ren), 64'(1'b0));
        chk("lk2_rsp", 64'(rsp_valid), 64'(2'b10));
        chk("lk2_rdata", 64'(rsp_rdata), 64'(32'hCAFEF00D));
        next_cycle();
        drive(2'b11, 2'b10, 2'b00, 8'h10, 8'h20, 32'h0, 32'hA5A50001);
        chk("lk3_ready", 64'(req_ready), 64'(2'b10));
        chk("lk3_wen", 64'(bank_wen), 64'(1'b1));
        chk("lk3_wdata", 64'(bank_wdata), 64'(32'hA5A50001));
        chk("lk3_rsp", 64'(rsp_valid), 64'(2'b00));
        next_cycle();
        drive(2'b11, 2'b00, 2'b00, 8'h10, 8'h20, 32'h0, 32'h0);
        chk("lk4_ready", 64'(req_ready), 64'(2'b01));
        chk("lk4_rsp", 64'(rsp_valid), 64'(2'b10));
        chk("lk4_rdata", 64'(rsp_rdata), 64'(32'hA5A50001));
        next_cycle();
        idle();
        chk("lk5_rsp", 64'(rsp_valid), 64'(2'b01));

        // Reset one cycle after a locked read: response and lock both dropped
        next_cycle();
        drive(2'b01, 2'b00, 2'b01, 8'h05, 8'h00, 32'h0, 32'h0);
        chk("mr0_ready", 64'(req_ready), 64'(2'b01));
        next_cycle();
        rst = 1'b1;
        idle();
        chk("mr1_rsp", 64'(rsp_valid), 64'(2'b00));
        chk("mr1_rdata", 64'(rsp_rdata), 64'(32'h0));
        next_cycle();
        rst = 1'b0;
        drive(2'b10, 2'b00, 2'b00, 8'h00, 8'h20, 32'h0, 32'h0);
        chk("mr2_ready_arb", 64'(req_ready), 64'(2'b10));
        chk("mr2_rsp", 64'(rsp_valid), 64'(2'b00));
        next_cycle();
        idle();
        chk("mr3_rsp", 64'(rsp_valid), 64'(2'b10));
        chk("mr3_rdata", 64'(rsp_rdata), 64'(32'hA5A50001));

        // Write-through to 0xFF, then read back
        next_cycle();
        drive(2'b01, 2'b01, 2'b00, 8'hFF, 8'h00, 32'h12345678, 32'h0);
        chk("wt0_ready", 64'(req_ready), 64'(2'b01));
        chk("wt0_wen", 64'(bank_wen), 64'(1'b1));
        chk("wt0_ren", 64'(bank_ren), 64'(1'b0));
        chk("wt0_addr", 64'(bank_addr), 64'(8'hFF));
        next_cycle();
        drive(2'b01, 2'b00, 2'b00, 8'hFF, 8'h00, 32'h0, 32'h0);
        chk("wt1_ready", 64'(req_ready), 64'(2'b01));
        chk("wt1_rsp", 64'(rsp_valid), 64'(2'b01));
        chk("wt1_rdata", 64'(rsp_rdata), 64'(32'h12345678));
        next_cycle();
        idle();
        chk("wt2_rsp", 64'(rsp_valid), 64'(2'b01));
        chk("wt2_rdata", 64'(rsp_rdata), 64'(32'h12345678));

        // Stray bank_rvalid with nothing in flight
        next_cycle();
        inj_rvalid = 1'b1;
        idle();
        chk("stray_rsp", 64'(rsp_valid), 64'(2'b00));
        chk("stray_rdata", 64'(rsp_rdata), 64'(32'h0));

        // Requester 0 holds a lock while requester 1 waits three cycles
        next_cycle();
        inj_rvalid = 1'b0;
        rst = 1'b1;
        idle();
        next_cycle();
        rst = 1'b0;
        drive(2'b01, 2'b00, 2'b01, 8'h10, 8'h00, 32'h0, 32'h0);
        chk("pc1_ready", 64'(req_ready), 64'(2'b01));
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            drive(2'b10, 2'b00, 2'b00, 8'h00, 8'h20, 32'h0, 32'h0);
            chk("pc_blocked", 64'(req_ready), 64'(2'b00));
        end
        next_cycle();
        drive(2'b01, 2'b01, 2'b00, 8'h10, 8'h00, 32'hDEADBEEF, 32'h0);
        chk("pc5_ready", 64'(req_ready), 64'(2'b01));
        next_cycle();
        idle();
        chk("pc6_rsp", 64'(rsp_valid), 64'(2'b01));
`ifdef SCRATCHPAD_ARB_PERF_CNT_EN
        chk("cnt1", 64'(conflict_cnt[1]), 64'(16'd3));
        chk("cnt0", 64'(conflict_cnt[0]), 64'(16'd0));
`endif

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
